fetch_unit: RTL and testbench



---
 rtl/core_pkg.sv | 15 +
 rtl/fetch_unit_if.sv | 18 +
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle core pipeline stages.
//   fetch_state_t : fetch unit FSM states (IDLE, WAIT)
//   INSTR_W       : instruction width in bits
//   PC_STEP       : sequential PC increment in bytes
package core_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory (synchronous BRAM) read port.
//   imem_en    : read enable, one cycle per fetch
//   imem_addr  : word address (byte address >> 2)
//   imem_rdata : read data, valid MEM_LATENCY cycles after imem_en
// master = fetch unit, slave = memory.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  import core_pkg::*;

  logic                imem_en;
  logic [ADDR_W-3:0]   imem_addr;
  logic [INSTR_W-1:0]  imem_rdata;

  modport master (output imem_en, output imem_addr, input  imem_rdata);
  modport slave  (input  imem_en, input  imem_addr, output imem_rdata);

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: responder of the fetch_enable/fetch_done handshake.
// Owns the architectural PC, issues one BRAM read per fetch, latches the
// instruction with its PC and pulses fetch_done MEM_LATENCY+2 cycles after
// fetch_enable.
//   clk, rst       : clock, synchronous active-high reset
//   fetch_enable   : one-cycle start pulse
//   fetch_done     : one-cycle completion pulse
//   pc_next_valid  : redirect strobe; pc_next is the target (bits [1:0] ignored)
//   imem           : BRAM read port (master side)
//   instr, pc_out  : fetched instruction and its PC, held until next fetch_done
//   proto_err      : sticky, fetch_enable seen while a fetch is in flight
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       MEM_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_enable,
  output logic               fetch_done,
  input  logic               pc_next_valid,
  input  logic [ADDR_W-1:0]  pc_next,
  fetch_unit_if.master       imem,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               proto_err
);

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  fetch_state_t      r_state, w_state_nxt;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_redir;
  logic [ADDR_W-1:0] w_pc_next_al;
  logic [ADDR_W-1:0] w_eff_pc;
  logic              w_launch;
  logic              w_complete;
  logic              w_unused;

  assign w_pc_next_al = {pc_next[ADDR_W-1:2], 2'b00};
  assign w_unused     = ^pc_next[1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_complete  = 1'b0;
    // Same-cycle redirect bypasses the PC register.
    w_eff_pc    = pc_next_valid ? w_pc_next_al : r_pc;
    case (r_state)
      IDLE: begin
        if (fetch_enable) begin
          w_launch    = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // cnt reaches zero in the cycle the BRAM data is valid.
        if (r_cnt == '0) begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_done     <= 1'b0;
      imem.imem_en   <= 1'b0;
      imem.imem_addr <= '0;
      instr          <= '0;
      pc_out         <= RESET_PC;
      proto_err      <= 1'b0;
      r_cnt          <= '0;
      r_pc           <= RESET_PC;
      r_fetch_pc     <= RESET_PC;
      r_redir        <= 1'b0;
    end else begin
      imem.imem_en <= w_launch;
      fetch_done   <= w_complete;
      if (w_launch) begin
        imem.imem_addr <= w_eff_pc[ADDR_W-1:2];
        r_cnt          <= LAT;
        r_fetch_pc     <= w_eff_pc;
        r_pc           <= w_eff_pc;
        r_redir        <= 1'b0;
      end else if (r_state == WAIT) begin
        if (r_cnt != '0) r_cnt <= r_cnt - 3'd1;
        if (fetch_enable) proto_err <= 1'b1;
        // A redirect seen at any point of the fetch (including the
        // completion cycle) overrides the sequential PC+4 update.
        if (pc_next_valid) begin
          r_pc    <= w_pc_next_al;
          r_redir <= 1'b1;
        end else if (w_complete && !r_redir) begin
          r_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
        end
        if (w_complete) begin
          instr  <= imem.imem_rdata;
          pc_out <= r_fetch_pc;
        end
      end else if (pc_next_valid) begin
        r_pc <= w_pc_next_al;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import core_pkg::*;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fen, pnv;
  logic [31:0] pn;

  logic [NI-1:0]       done_v, en_v, err_v;
  logic [NI-1:0][29:0] addr_v;
  logic [NI-1:0][31:0] instr_v, pcout_v, noise_v;

  logic [3:0]  bv [NI] = '{default: '0};
  logic [31:0] bd [NI][4];

  int vectors = 0;
  int errors  = 0;

  function automatic int lat_of(int g);
    return (g == 0) ? 2 : 3;
  endfunction

  function automatic logic [31:0] mem_word(logic [29:0] a);
    if (a == 30'd0) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96 ^ {2'b00, a};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 2 : 3;
    fetch_unit_if #(.ADDR_W(32)) bus ();
    fetch_unit #(
      .ADDR_W(32),
      .RESET_PC(32'h0),
      .MEM_LATENCY(LAT)
    ) dut (
      .clk(clk),
      .rst(rst),
      .fetch_enable(fen),
      .fetch_done(done_v[g]),
      .pc_next_valid(pnv),
      .pc_next(pn),
      .imem(bus),
      .instr(instr_v[g]),
      .pc_out(pcout_v[g]),
      .proto_err(err_v[g])
    );
    assign en_v[g]   = bus.imem_en;
    assign addr_v[g] = bus.imem_addr;
    // Data is only meaningful in the valid cycle; otherwise random junk.
    assign bus.imem_rdata = bv[g][LAT-1] ? bd[g][LAT-1] : noise_v[g];
  end

  // BRAM model: fixed-latency pipeline of (valid, data).
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      bv[g]    <= {bv[g][2:0], en_v[g]};
      bd[g][0] <= mem_word(addr_v[g]);
      for (int k = 1; k < 4; k++) bd[g][k] <= bd[g][k-1];
      noise_v[g] <= $urandom;
    end
  end

  // Behavioural model: transaction timestamps instead of a state machine.
  logic        e_en [NI], e_done [NI], e_err [NI], busy [NI], redir [NI];
  logic [29:0] e_addr [NI];
  logic [31:0] e_instr [NI], e_pcout [NI], m_pc [NI], fpc [NI];
  longint      launch [NI];
  longint      cyc   = 0;
  bit          armed = 1'b0;

  initial begin : model
    forever begin
      @(posedge clk);
      for (int g = 0; g < NI; g++) begin
        if (rst) begin
          e_en[g] = 1'b0; e_done[g] = 1'b0; e_err[g] = 1'b0;
          e_addr[g] = '0; e_instr[g] = '0; e_pcout[g] = '0;
          m_pc[g] = '0; busy[g] = 1'b0; redir[g] = 1'b0;
          armed = 1'b1;
        end else begin
          e_en[g]   = 1'b0;
          e_done[g] = 1'b0;
          if (busy[g]) begin
            if (fen) e_err[g] = 1'b1;
            if (pnv) begin
              m_pc[g]  = pn & 32'hFFFF_FFFC;
              redir[g] = 1'b1;
            end
            if (cyc == launch[g] + 1 + lat_of(g)) begin
              e_done[g]  = 1'b1;
              e_instr[g] = mem_word(fpc[g][31:2]);
              e_pcout[g] = fpc[g];
              if (!redir[g]) m_pc[g] = fpc[g] + 32'd4;
              busy[g] = 1'b0;
            end
          end else if (fen) begin
            fpc[g]    = pnv ? (pn & 32'hFFFF_FFFC) : m_pc[g];
            launch[g] = cyc;
            busy[g]   = 1'b1;
            redir[g]  = 1'b0;
            e_en[g]   = 1'b1;
            e_addr[g] = fpc[g][31:2];
          end else if (pnv) begin
            m_pc[g] = pn & 32'hFFFF_FFFC;
          end
        end
      end
      cyc++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int g = 0; g < NI; g++) begin
          check($sformatf("done[%0d]", g),  32'(done_v[g]),  32'(e_done[g]));
          check($sformatf("en[%0d]", g),    32'(en_v[g]),    32'(e_en[g]));
          check($sformatf("addr[%0d]", g),  32'(addr_v[g]),  32'(e_addr[g]));
          check($sformatf("instr[%0d]", g), instr_v[g],      e_instr[g]);
          check($sformatf("pcout[%0d]", g), pcout_v[g],      e_pcout[g]);
          check($sformatf("err[%0d]", g),   32'(err_v[g]),   32'(e_err[g]));
        end
      end
    end
  end

  task automatic cyc_in(input bit f, input bit v, input logic [31:0] p, input bit r);
    fen = f; pnv = v; pn = p; rst = r;
    @(posedge clk);
    #1;
    fen = 1'b0; pnv = 1'b0; pn = '0; rst = 1'b0;
  endtask

  task automatic check_reset_vals(input int g);
    check("rst_done",  32'(done_v[g]), 32'd0);
    check("rst_en",    32'(en_v[g]),   32'd0);
    check("rst_addr",  32'(addr_v[g]), 32'd0);
    check("rst_instr", instr_v[g],     32'd0);
    check("rst_pcout", pcout_v[g],     32'd0);
    check("rst_err",   32'(err_v[g]),  32'd0);
  endtask

  // Wait for instance 0 done (bounded); returns cycles waited.
  task automatic wait_done0(output int n);
    n = 0;
    while (!done_v[0] && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic fetch(input bit v, input logic [31:0] p,
                       input logic [29:0] exp_addr, input logic [31:0] exp_pc);
    int n;
    cyc_in(1'b1, v, p, 1'b0);
    check("lit_en",   32'(en_v[0]),   32'd1);
    check("lit_addr", 32'(addr_v[0]), 32'(exp_addr));
    wait_done0(n);
    check("lit_latency", 32'(n), 32'd3);
    check("lit_instr", instr_v[0], mem_word(exp_pc[31:2]));
    check("lit_pcout", pcout_v[0], exp_pc);
    repeat (2) cyc_in(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin : stim
    int n, dn;
    rst = 1'b1; fen = 1'b0; pnv = 1'b0; pn = '0;
    repeat (2) cyc_in(1'b0, 1'b0, '0, 1'b1);
    for (int g = 0; g < NI; g++) check_reset_vals(g);

    // Basic fetch then sequential next fetch.
    fetch(1'b0, '0, 30'h0, 32'h0);
    check("basic_instr", instr_v[0], 32'h0050_0093);
    fetch(1'b0, '0, 30'h1, 32'h4);

    // Redirect mid-WAIT.
    cyc_in(1'b0, 1'b1, 32'h4, 1'b0);
    cyc_in(1'b1, 1'b0, '0, 1'b0);
    cyc_in(1'b0, 1'b0, '0, 1'b0);
    cyc_in(1'b0, 1'b1, 32'h100, 1'b0);
    @(posedge clk); #1;
    check("redir_done",  32'(done_v[0]), 32'd1);
    check("redir_pcout", pcout_v[0], 32'h4);
    check("redir_instr", instr_v[0], mem_word(30'h1));
    repeat (2) cyc_in(1'b0, 1'b0, '0, 1'b0);
    fetch(1'b0, '0, 30'h40, 32'h100);

    // Simultaneous redirect and enable.
    fetch(1'b1, 32'h200, 30'h80, 32'h200);
    fetch(1'b0, '0, 30'h81, 32'h204);

    // Protocol error: second enable in cycle 2 of a fetch.
    cyc_in(1'b1, 1'b0, '0, 1'b0);
    cyc_in(1'b0, 1'b0, '0, 1'b0);
    cyc_in(1'b1, 1'b0, '0, 1'b0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_v[0]) dn++;
      cyc_in(1'b0, 1'b0, '0, 1'b0);
    end
    check("proto_done_count", 32'(dn), 32'd1);
    check("proto_err0", 32'(err_v[0]), 32'd1);
    check("proto_err1", 32'(err_v[1]), 32'd1);
    fetch(1'b0, '0, 30'h83, 32'h20C);
    check("proto_sticky", 32'(err_v[0]), 32'd1);

    // Reset mid-WAIT.
    cyc_in(1'b1, 1'b0, '0, 1'b0);
    cyc_in(1'b0, 1'b0, '0, 1'b0);
    cyc_in(1'b0, 1'b0, '0, 1'b1);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_v != '0) dn++;
      cyc_in(1'b0, 1'b0, '0, 1'b0);
    end
    check("rst_no_done", 32'(dn), 32'd0);
    for (int g = 0; g < NI; g++) check_reset_vals(g);
    fetch(1'b0, '0, 30'h0, 32'h0);

    // Wrap-around.
    cyc_in(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    fetch(1'b0, '0, 30'h3FFF_FFFF, 32'hFFFF_FFFC);
    fetch(1'b0, '0, 30'h0, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cyc_in(($urandom % 4) == 0, ($urandom % 8) == 0, $urandom, ($urandom % 150) == 0);
    end
    repeat (8) cyc_in(1'b0, 1'b0, '0, 1'b0);
    wait_done0(n);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
